// File: rtl/uart_pattern_gen.sv
// Pattern generator that feeds a UART transmitter with paced write strobes.
// Words follow one of four rules (increment, fixed, rotate-left, complement) from a seed.
module uart_pattern_gen #(
  parameter int DATA_W = 8,
  parameter int GAP_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [GAP_W-1:0]  interval,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              tx_idle,
  output logic [DATA_W-1:0] dataout,
  output logic              wrsig,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [1:0] M_INC  = 2'd0;
  localparam logic [1:0] M_FIX  = 2'd1;
  localparam logic [1:0] M_ROT  = 2'd2;
  localparam logic [1:0] M_COMP = 2'd3;

  state_t            r_state;
  logic [GAP_W-1:0]  r_cnt;
  logic [1:0]        r_mode;

  logic              w_gap_done;
  logic [DATA_W-1:0] w_next_word;
  logic [CNT_W-1:0]  w_next_count;
  logic              w_burst_hit;

  // >= rather than == so a run cannot stall if interval is lowered below the count mid-gap.
  assign w_gap_done   = (r_cnt >= interval);
  assign w_next_count = sent_count + CNT_W'(1);
  assign w_burst_hit  = (burst_len != '0) && (w_next_count == burst_len);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next_word = dataout;
    case (r_mode)
      M_INC:   w_next_word = dataout + DATA_W'(1);
      M_FIX:   w_next_word = dataout;
      M_ROT:   w_next_word = {dataout[DATA_W-2:0], dataout[DATA_W-1]};
      M_COMP:  w_next_word = ~dataout;
      default: w_next_word = dataout;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; reset is asynchronous so outputs clear without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mode     <= M_INC;
      dataout    <= '0;
      wrsig      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          wrsig <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (enable) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            r_mode     <= mode;
            dataout    <= seed;
            sent_count <= '0;
            busy       <= 1'b1;
          end
        end

        S_WAIT: begin
          if (!enable) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (w_gap_done && tx_idle) begin
            r_state <= S_SEND;
            wrsig   <= 1'b1;
          end else if (!w_gap_done) begin
            r_cnt <= r_cnt + GAP_W'(1);
          end
        end

        S_SEND: begin
          // The strobe already issued counts even when enable has just dropped.
          wrsig      <= 1'b0;
          sent_count <= w_next_count;
          dataout    <= w_next_word;
          if (!enable) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (w_burst_hit) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end

        S_DONE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            done    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          wrsig   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Bench for uart_pattern_gen: a phase-level model checked every cycle against two
// instances (16-bit and 3-bit sent_count), plus directed runs with literal expectations.
module tb_uart_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [15:0] interval;
  logic [15:0] burst_len;
  logic        tx_idle;

  logic [7:0]  dataout;
  logic        wrsig, busy, done;
  logic [15:0] sent_count;

  logic [7:0]  dataout_s;
  logic        wrsig_s, busy_s, done_s;
  logic [2:0]  sent_count_s;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  uart_pattern_gen u_dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .seed(seed),
    .interval(interval), .burst_len(burst_len), .tx_idle(tx_idle),
    .dataout(dataout), .wrsig(wrsig), .busy(busy), .done(done),
    .sent_count(sent_count)
  );

  uart_pattern_gen #(.DATA_W(8), .GAP_W(16), .CNT_W(3)) u_dut_s (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .seed(seed),
    .interval(interval), .burst_len(burst_len[2:0]), .tx_idle(tx_idle),
    .dataout(dataout_s), .wrsig(wrsig_s), .busy(busy_s), .done(done_s),
    .sent_count(sent_count_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_OFF, PH_GAP, PH_STROBE, PH_HOLD} phase_t;
  typedef struct {
    phase_t ph;
    int     elapsed;
    int     word;
    int     pat;
    int     count;
  } model_t;

  model_t mm = '{PH_OFF, 0, 0, 0, 0};
  model_t ms = '{PH_OFF, 0, 0, 0, 0};

  function automatic int next_word(input int w, input int pat);
    case (pat)
      0:       return (w + 1) % 256;
      2:       return ((w * 2) % 256) + (w / 128);
      3:       return 255 - w;
      default: return w;
    endcase
  endfunction

  function automatic model_t step(input model_t m, input int mask);
    model_t n = m;
    int bl = int'(burst_len) & mask;
    case (m.ph)
      PH_OFF: if (enable) begin
        n.ph = PH_GAP; n.elapsed = 0; n.word = int'(seed); n.pat = int'(mode); n.count = 0;
      end
      PH_GAP: begin
        if (!enable) n.ph = PH_OFF;
        else if (m.elapsed >= int'(interval)) begin
          if (tx_idle) n.ph = PH_STROBE;
        end else n.elapsed = m.elapsed + 1;
      end
      PH_STROBE: begin
        n.count = (m.count + 1) & mask;
        n.word  = next_word(m.word, m.pat);
        if (!enable) n.ph = PH_OFF;
        else if (bl != 0 && n.count == bl) n.ph = PH_HOLD;
        else begin n.ph = PH_GAP; n.elapsed = 0; end
      end
      PH_HOLD: if (!enable) n.ph = PH_OFF;
      default: n.ph = PH_OFF;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm = '{PH_OFF, 0, 0, 0, 0};
      ms = '{PH_OFF, 0, 0, 0, 0};
    end else begin
      mm = step(mm, 32'hFFFF);
      ms = step(ms, 7);
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("wrsig",        32'(wrsig),        32'(mm.ph == PH_STROBE));
      check("busy",         32'(busy),         32'(mm.ph == PH_GAP || mm.ph == PH_STROBE));
      check("done",         32'(done),         32'(mm.ph == PH_HOLD));
      check("dataout",      32'(dataout),      32'(mm.word));
      check("sent_count",   32'(sent_count),   32'(mm.count));
      check("s_wrsig",      32'(wrsig_s),      32'(ms.ph == PH_STROBE));
      check("s_done",       32'(done_s),       32'(ms.ph == PH_HOLD));
      check("s_dataout",    32'(dataout_s),    32'(ms.word));
      check("s_sent_count", 32'(sent_count_s), 32'(ms.count));
    end
  end

  // ---------------- directed helpers ----------------
  time last_strobe;

  task automatic wait_strobe(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (wrsig) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [7:0] s,
                           input logic [15:0] iv, input logic [15:0] bl);
    mode = m; seed = s; interval = iv; burst_len = bl; enable = 1'b1;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    @(negedge clk);
    check("stop_busy",  32'(busy),  32'd0);
    check("stop_wrsig", 32'(wrsig), 32'd0);
    check("stop_done",  32'(done),  32'd0);
  endtask

  task automatic strobe_seq(input string tag, input int n, input int spacing,
                            input logic [7:0] exp0, input logic [7:0] exp1,
                            input logic [7:0] exp2, input logic [7:0] exp3);
    logic [7:0] exp_tab [4];
    bit ok;
    exp_tab = '{exp0, exp1, exp2, exp3};
    for (int k = 0; k < n; k++) begin
      wait_strobe(spacing * 4 + 20, ok);
      check({tag, "_seen"}, 32'(ok), 32'd1);
      check({tag, "_data"}, 32'(dataout), 32'(exp_tab[k]));
      if (k > 0) check({tag, "_spacing"}, 32'(($time - last_strobe) / 10), 32'(spacing));
      last_strobe = $time;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; seed = 8'h00;
    interval = 16'd0; burst_len = 16'd0; tx_idle = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dataout",    32'(dataout),    32'd0);
    check("rst_wrsig",      32'(wrsig),      32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_sent_count", 32'(sent_count), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_wrsig", 32'(wrsig), 32'd0);

    // Alternate-complement, back-to-back strobes.
    start_run(2'd3, 8'h55, 16'd0, 16'd0);
    strobe_seq("comp", 3, 2, 8'h55, 8'hAA, 8'h55, 8'h00);
    stop_run();

    // Walking rotate, burst of four then DONE.
    start_run(2'd2, 8'h01, 16'd2, 16'd4);
    strobe_seq("rot", 4, 4, 8'h01, 8'h02, 8'h04, 8'h08);
    @(negedge clk);
    check("burst_done",  32'(done),       32'd1);
    check("burst_busy",  32'(busy),       32'd0);
    check("burst_count", 32'(sent_count), 32'd4);
    repeat (3) @(negedge clk);
    check("burst_hold_done",  32'(done),       32'd1);
    check("burst_hold_count", 32'(sent_count), 32'd4);
    stop_run();

    // Transmitter back-pressure at the end of the gap.
    tx_idle = 1'b0;
    start_run(2'd0, 8'h10, 16'd5, 16'd0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_no_wrsig", 32'(wrsig),   32'd0);
      check("bp_data",     32'(dataout), 32'h10);
    end
    tx_idle = 1'b1;
    @(negedge clk);
    check("bp_wrsig", 32'(wrsig),   32'd1);
    check("bp_data2", 32'(dataout), 32'h10);
    stop_run();
    check("bp_count_after_stop", 32'(sent_count), 32'd1);

    // Enable dropped in WAIT, then restart from the seed.
    start_run(2'd1, 8'h77, 16'd1, 16'd0);
    wait_strobe(20, ok);
    check("drop_first_strobe", 32'(ok), 32'd1);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_busy",  32'(busy),  32'd0);
      check("drop_wrsig", 32'(wrsig), 32'd0);
    end
    check("drop_count_held", 32'(sent_count), 32'd1);
    start_run(2'd1, 8'h33, 16'd1, 16'd0);
    @(negedge clk);
    check("restart_busy",  32'(busy),       32'd1);
    check("restart_data",  32'(dataout),    32'h33);
    check("restart_count", 32'(sent_count), 32'd0);
    stop_run();

    // Asynchronous reset in the middle of a SEND cycle.
    start_run(2'd0, 8'hA0, 16'd3, 16'd0);
    wait_strobe(20, ok);
    check("mid_rst_strobe", 32'(ok), 32'd1);
    wait_strobe(20, ok);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wrsig",      32'(wrsig),      32'd0);
    check("mid_rst_busy",       32'(busy),       32'd0);
    check("mid_rst_done",       32'(done),       32'd0);
    check("mid_rst_dataout",    32'(dataout),    32'd0);
    check("mid_rst_sent_count", 32'(sent_count), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // Long continuous increment run: full byte wrap, 3-bit count wraps many times.
    start_run(2'd0, 8'h00, 16'd253, 16'd0);
    for (int i = 0; i <= 256; i++) begin
      wait_strobe(300, ok);
      check("long_seen", 32'(ok), 32'd1);
      check("long_data", 32'(dataout), 32'(i & 255));
      if (i > 0) check("long_spacing", 32'(($time - last_strobe) / 10), 32'd255);
      last_strobe = $time;
      if (i == 255) begin
        @(negedge clk);
        check("long_count_256", 32'(sent_count), 32'd256);
      end
    end
    stop_run();

    // Randomized operation against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mode    = 2'($urandom_range(0, 3));
      seed    = 8'($urandom);
      tx_idle = ($urandom_range(0, 3) != 0);
      if (!enable) begin
        interval = 16'($urandom_range(0, 6));
        if ($urandom_range(0, 3) == 0) begin
          burst_len = 16'($urandom_range(0, 5));
          enable    = 1'b1;
        end
      end else begin
        if ($urandom_range(0, 99) == 0) burst_len = 16'($urandom_range(0, 5));
        if ($urandom_range(0, 59) == 0) enable = 1'b0;
      end
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_pattern_gen.md
UART_PATTERN_GEN -- requirements
Module: uart_pattern_gen

Interface
REQ-001 Parameter DATA_W, default 8, width of the generated data word.
REQ-002 Parameter GAP_W, default 16, width of the interval input and gap counter.
REQ-003 Parameter CNT_W, default 16, width of burst_len and sent_count.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  run request; level-sensitive.
REQ-007 mode  input  2  pattern select: 0 increment, 1 fixed, 2 walking rotate-left, 3 alternate-complement.
REQ-008 seed  input  DATA_W  first word of a run.
REQ-009 interval  input  GAP_W  gap setting; strobe period is interval+2 cycles when tx_idle is held high.
REQ-010 burst_len  input  CNT_W  words per run; 0 means continuous.
REQ-011 tx_idle  input  1  downstream UART transmitter ready to accept a word.
REQ-012 dataout  output  DATA_W  word presented to the transmitter.
REQ-013 wrsig  output  1  one-cycle write strobe; dataout is valid while it is high.
REQ-014 busy  output  1  high in WAIT and SEND.
REQ-015 done  output  1  high in DONE.
REQ-016 sent_count  output  CNT_W  words strobed in the current run.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, SEND and DONE; all outputs SHALL be registered.
REQ-018 IDLE with enable=1 SHALL go to WAIT and set cnt=0, dataout=seed and sent_count=0.
REQ-019 mode SHALL be latched only on the IDLE->WAIT transition and ignored at all other times.
REQ-020 WAIT SHALL increment cnt each cycle, saturating at interval.
REQ-021 WAIT SHALL go to SEND when cnt==interval and tx_idle=1 in the same cycle.
REQ-022 If cnt==interval and tx_idle=0, WAIT SHALL hold with dataout unchanged until tx_idle=1.
REQ-023 SEND SHALL last exactly one cycle, with wrsig=1 and dataout equal to the current word.
REQ-024 On SEND exit: sent_count+1, and dataout takes the next word.
REQ-025 On SEND exit, next state SHALL be DONE if burst_len!=0 and the new sent_count==burst_len, else WAIT with cnt=0.
REQ-026 Next word SHALL be: mode 0 dataout+1 modulo 2^DATA_W; mode 1 unchanged.
REQ-027 Next word SHALL be: mode 2 rotate left by 1 (MSB to LSB); mode 3 bitwise complement.
REQ-028 With interval=0 and tx_idle=1, wrsig SHALL pulse every 2 cycles.
REQ-029 In continuous mode, sent_count SHALL wrap 2^CNT_W-1 -> 0 with no effect on generation.
REQ-030 DONE SHALL hold done=1 and the final sent_count until enable=0, then go to IDLE.
REQ-031 enable=0 in WAIT or SEND SHALL force IDLE on the next edge.
REQ-032 An in-progress SEND cycle completes its single strobe; no further wrsig SHALL issue after enable=0 is sampled.
REQ-033 In IDLE, wrsig, busy and done SHALL be 0, and dataout and sent_count SHALL hold their last values.
REQ-034 A changed burst_len during a run SHALL take effect at the next SEND exit comparison.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, cnt=0, dataout=0, wrsig=0, busy=0, done=0 and sent_count=0, regardless of clock, including mid-run.
REQ-036 After rst is released, no wrsig SHALL occur until enable=1 is sampled in IDLE.

Verification
REQ-037 Reset asserted mid-run during SEND -> wrsig, busy, done, dataout and sent_count all 0 before the next clock edge.
REQ-038 DATA_W=8, mode 0, seed 0x00, interval 253, burst 0, tx_idle=1 -> wrsig every 255 cycles; data 0x00,0x01,...,0xFF,0x00; sent_count 256 after 256 strobes.
REQ-039 mode 2, seed 0x01, interval 2, burst 4 -> strobes 4 cycles apart with data 0x01,0x02,0x04,0x08; then done=1, busy=0, sent_count=4; enable=0 -> IDLE next cycle.
REQ-040 mode 0, interval 5, tx_idle low for 10 cycles after cnt reaches 5 -> no wrsig while low; wrsig on the cycle after tx_idle rises; data unchanged.
REQ-041 mode 3, seed 0x55, interval 0 -> data 0x55,0xAA,0x55 on consecutive strobes 2 cycles apart.
REQ-042 enable dropped in WAIT then reasserted -> IDLE next cycle with no wrsig; the restart begins at seed with sent_count=0.
